// File: rtl/core_pkg.sv
// Shared divider definitions: FSM state encoding and the special-case constants
// used when detecting divide-by-zero and signed overflow.
package core_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the quotient MSB into the partial
// remainder and subtract the divisor magnitude when it fits.
module div_step #(
  parameter int BUS_WIDTH = 64
) (
  input  logic [BUS_WIDTH:0]   i_rem,
  input  logic [BUS_WIDTH-1:0] i_quo,
  input  logic [BUS_WIDTH-1:0] i_dsr,
  output logic [BUS_WIDTH:0]   o_rem,
  output logic [BUS_WIDTH-1:0] o_quo
);

  logic [BUS_WIDTH+1:0] w_rem_sh;
  logic [BUS_WIDTH+1:0] w_dsr_ext;
  logic                 w_ge;

  assign w_rem_sh  = {i_rem, i_quo[BUS_WIDTH-1]};
  assign w_dsr_ext = {2'b00, i_dsr};
  assign w_ge      = (w_rem_sh >= w_dsr_ext);

  assign o_rem = w_ge ? (BUS_WIDTH+1)'(w_rem_sh - w_dsr_ext) : w_rem_sh[BUS_WIDTH:0];
  assign o_quo = {i_quo[BUS_WIDTH-2:0], w_ge};

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU. Stalls the
// pipeline while iterating and presents the result in a single done cycle.
module seq_divider
  import core_pkg::*;
#(
  parameter int BUS_WIDTH = 64,
  parameter int CNT_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 kill,
  input  logic                 is_signed,
  input  logic                 is_rem,
  input  logic [BUS_WIDTH-1:0] dividend,
  input  logic [BUS_WIDTH-1:0] divisor,
  output logic                 div_stall,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] result
);

  localparam logic [BUS_WIDTH-1:0] L_ONES     = DIV_ZERO_Q[XLEN-1 -: BUS_WIDTH];
  localparam logic [BUS_WIDTH-1:0] L_MIN      = SIGNED_MIN[XLEN-1 -: BUS_WIDTH];
  localparam logic [CNT_WIDTH-1:0] L_CNT_LAST = CNT_WIDTH'(BUS_WIDTH - 1);

  div_state_e r_state;
  div_state_e w_state_next;

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [BUS_WIDTH:0]   r_rem;
  logic [BUS_WIDTH-1:0] r_quo;
  logic [BUS_WIDTH-1:0] r_dsr;
  logic [BUS_WIDTH-1:0] r_result;
  logic                 r_is_rem;
  logic                 r_neg_q;
  logic                 r_neg_r;

  logic                 w_accept;
  logic                 w_dvd_neg;
  logic                 w_dsr_neg;
  logic [BUS_WIDTH-1:0] w_dvd_mag;
  logic [BUS_WIDTH-1:0] w_dsr_mag;
  logic                 w_div_zero;
  logic                 w_ovf;
  logic                 w_special;
  logic [BUS_WIDTH-1:0] w_special_res;
  logic [BUS_WIDTH:0]   w_step_rem;
  logic [BUS_WIDTH-1:0] w_step_quo;
  logic [BUS_WIDTH-1:0] w_quo_signed;
  logic [BUS_WIDTH-1:0] w_rem_signed;

  // Operand decode happens only in the acceptance cycle; later changes are ignored.
  assign w_dvd_neg  = is_signed & dividend[BUS_WIDTH-1];
  assign w_dsr_neg  = is_signed & divisor[BUS_WIDTH-1];
  assign w_dvd_mag  = w_dvd_neg ? (~dividend + 1'b1) : dividend;
  assign w_dsr_mag  = w_dsr_neg ? (~divisor + 1'b1) : divisor;
  assign w_div_zero = (divisor == '0);
  assign w_ovf      = is_signed & (dividend == L_MIN) & (divisor == L_ONES);
  assign w_special  = w_div_zero | w_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = is_rem ? dividend : L_ONES;
    end else if (!is_rem) begin
      w_special_res = dividend;
    end
  end

  div_step #(
    .BUS_WIDTH (BUS_WIDTH)
  ) u_div_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dsr (r_dsr),
    .o_rem (w_step_rem),
    .o_quo (w_step_quo)
  );

  assign w_quo_signed = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign w_rem_signed = r_neg_r ? (~r_rem[BUS_WIDTH-1:0] + 1'b1) : r_rem[BUS_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    div_stall    = 1'b0;
    done         = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !kill) begin
          w_accept     = 1'b1;
          div_stall    = 1'b1;
          w_state_next = w_special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        div_stall = 1'b1;
        if (r_cnt == '0) begin
          w_state_next = S_FIX;
        end
      end
      S_FIX: begin
        div_stall    = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        // start seen here still belongs to the retiring instruction
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (kill) begin
      w_state_next = S_IDLE;
      div_stall    = 1'b0;
      done         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dsr    <= '0;
      r_result <= '0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (w_accept) begin
      r_is_rem <= is_rem;
      r_neg_q  <= w_dvd_neg ^ w_dsr_neg;
      r_neg_r  <= w_dvd_neg;
      if (w_special) begin
        r_result <= w_special_res;
      end else begin
        r_quo <= w_dvd_mag;
        r_rem <= '0;
        r_dsr <= w_dsr_mag;
        r_cnt <= L_CNT_LAST;
      end
    end else if (r_state == S_CALC && !kill) begin
      r_rem <= w_step_rem;
      r_quo <= w_step_quo;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end else if (r_state == S_FIX && !kill) begin
      r_result <= r_is_rem ? w_rem_signed : w_quo_signed;
    end
  end

  assign result = r_result;

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative radix-2 integer divider that performs the division work behind the EX stage's divide stall. The EX stage raises `start` for a divide or remainder instruction. The divider holds `div_stall` high while it iterates, then presents `result` in a single `done` cycle, when the pipeline advances. It implements RISC-V M-extension semantics for DIV, DIVU, REM and REMU on BUS_WIDTH operands.

## Interface
Parameters:
- `BUS_WIDTH`, 64, operand and result width
- `CNT_WIDTH`, 6, iteration counter width (log2 of BUS_WIDTH)

Ports:
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous, active-low reset
- `start`  input  1  divide requested by the instruction currently in EX
- `kill`  input  1  synchronous flush; aborts any operation in flight
- `is_signed`  input  1  1 = DIV/REM, 0 = DIVU/REMU
- `is_rem`  input  1  1 = return remainder, 0 = return quotient
- `dividend`  input  BUS_WIDTH  rs1 operand
- `divisor`  input  BUS_WIDTH  rs2 operand
- `div_stall`  output  1  freeze IF/ID/EX this cycle
- `done`  output  1  `result` valid this cycle
- `result`  output  BUS_WIDTH  quotient or remainder

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- **IDLE**
  - `start & !kill` latches the operands, `is_signed` and `is_rem`.
  - If `divisor == 0` or signed overflow is detected, the special-case result is computed and the next state is DONE.
  - Otherwise the operand magnitudes are loaded, the counter is set to BUS_WIDTH-1, and the next state is CALC.
- **CALC** performs one restoring step per cycle:
  - remainder = {remainder, quotient MSB}; shift quotient left.
  - If remainder ≥ |divisor|: subtract, set quotient LSB = 1.
  - When the counter reaches 0, the next state is FIX; otherwise decrement the counter.
- **FIX** applies signs:
  - Quotient is negated if `is_signed` and the operand signs differ.
  - Remainder takes the dividend's sign.
  - Selects the quotient or remainder into the result register. Next state is DONE.
- **DONE**
  - `done = 1`; `result` holds the value.
  - `start` is ignored, because it still belongs to the retiring instruction.
  - Next state is IDLE unconditionally.
- Special cases:
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (dividend = 1 followed by zeros, divisor = all ones): quotient = dividend, remainder = 0.
- Stall equation: `div_stall = (IDLE & start & !kill) | CALC | FIX`.
  - `div_stall` is combinational from `start` in IDLE.
  - `div_stall` is low in DONE, so the pipeline captures `result` on that edge.
- `kill` in any state forces IDLE at the next edge. `done` never fires for the killed operation, and `div_stall` is 0 while `kill` is high.
- Operand changes after the IDLE acceptance edge are ignored.
- Widths:
  - Internal remainder register is BUS_WIDTH+1 bits so the compare does not overflow.
  - Magnitudes use two's-complement negation, which is exact for the most-negative value as unsigned.

## Timing
- Reset values: state = IDLE, `div_stall` = 0, `done` = 0, `result` = 0, counter = 0.
- Reset mid-operation returns to IDLE immediately (asynchronous). No `done` is produced.
- Normal latency, with `start` sampled at edge 0:
  - CALC occupies cycles 1..BUS_WIDTH.
  - FIX occupies cycle BUS_WIDTH+1.
  - DONE occupies cycle BUS_WIDTH+2, which is cycle 66 at 64 bits.
- Special-case latency: DONE in cycle 1.
- `done` is exactly one cycle wide.
- Back-to-back divides: a new `start` is accepted in the IDLE cycle following DONE. Minimum spacing is BUS_WIDTH+3 cycles.
- `result` holds its value until the next acceptance.

## Structure
- Shared `core_pkg` holds:
  - the FSM state encoding (2-bit),
  - `DIV_ZERO_Q` (all ones),
  - the signed-minimum constant.
- Optional combinational sub-module `div_step` for one restoring iteration: inputs remainder, quotient and divisor magnitude; outputs next remainder and next quotient. Everything else stays in `seq_divider`.
- Target size: 150–250 lines of RTL.

## Test plan
- Unsigned 100/7, `is_rem` = 0 then 1:
  - `result` = 14, then 2.
  - `done` in cycle 66; `div_stall` high in cycles 0..65.
- Signed -7/2:
  - Quotient = 0xFFFF_FFFF_FFFF_FFFD (-3).
  - Remainder = 0xFFFF_FFFF_FFFF_FFFF (-1).
  - Signed 7/-2: quotient -3, remainder 1.
- 5/0:
  - Quotient = all ones, remainder = 5.
  - `done` in cycle 1; `div_stall` high only in cycle 0.
- Signed 0x8000_0000_0000_0000 / -1:
  - Quotient = 0x8000_0000_0000_0000, remainder = 0, `done` in cycle 1.
  - Unsigned, same operands: quotient 0, remainder 0x8000_0000_0000_0000, 66-cycle latency.
- Kill and reset:
  - `kill` in cycle 30: IDLE next cycle, no `done`, a new `start` is accepted.
  - `rst` low in cycle 40: all outputs 0 immediately.
  - Back-to-back 100/7 then 9/3: second `result` = 3 in cycle 133.
